cdc_pulse_feeder: RTL and testbench

CDC_PULSE_FEEDER -- requirements
Module: cdc_pulse_feeder

---
 rtl/cdc_pulse_feeder_if.sv | 38 +++
 rtl/cdc_pulse_feeder.sv | 110 +++++++++++
 tb/tb_cdc_pulse_feeder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_pulse_feeder_if.sv
// Handshake bundle between an event source, the pulse feeder and the
// downstream cdc_pulse_sync instance. The feeder sits on the slave side.
interface cdc_pulse_feeder_if #(
    parameter int CW = 8
);
    logic          a_event_in;
    logic          a_clear_overflow;
    logic          a_sync_busy;
    logic          a_sync_pulse;
    logic [CW-1:0] a_pending;
    logic          a_full;
    logic          a_overflow;
    logic          a_idle;

    // Event source / downstream side: drives events, clear and busy.
    modport master (
        output a_event_in,
        output a_clear_overflow,
        output a_sync_busy,
        input  a_sync_pulse,
        input  a_pending,
        input  a_full,
        input  a_overflow,
        input  a_idle
    );

    // Feeder side.
    modport slave (
        input  a_event_in,
        input  a_clear_overflow,
        input  a_sync_busy,
        output a_sync_pulse,
        output a_pending,
        output a_full,
        output a_overflow,
        output a_idle
    );
endinterface

// File: rtl/cdc_pulse_feeder.sv
// Pulse feeder for a cdc_pulse_sync instance. Counts incoming one-cycle
// events and issues them one at a time, only when the downstream
// synchroniser reports not busy, so no pulse is ever lost to a busy
// handshake. The downstream cdc_pulse_sync must share a_reset with this
// block so that a reset never leaves a handshake half-finished on one side.
module cdc_pulse_feeder #(
    parameter int CW = 8
) (
    input  logic              a_clk,
    input  logic              a_reset,
    cdc_pulse_feeder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_sync_pulse;
    logic [CW-1:0] r_pending;
    logic          r_overflow;

    logic          w_in_issue;
    logic          w_full;
    logic          w_inc;
    logic          w_dec;
    logic          w_drop;

    assign w_in_issue = (r_state == ST_ISSUE);
    assign w_full     = (r_pending == {CW{1'b1}});

    // An event arriving on the issue cycle cancels against the issued one,
    // so the count is unchanged even when saturated and nothing is dropped.
    assign w_inc  = bus.a_event_in & ~w_in_issue & ~w_full;
    assign w_dec  = w_in_issue & ~bus.a_event_in;
    assign w_drop = bus.a_event_in & ~w_in_issue & w_full;

    // Next-state decode: leave IDLE only when work is queued and the
    // downstream handshake is free; WAIT until the handshake completes.
    always_comb begin
        // NOTE: assign a default before the case so every path drives the
        // signal; a missing branch in combinational logic infers a latch.
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if ((r_pending != '0) && !bus.a_sync_busy) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.a_sync_busy) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register plus a dedicated pulse flop, so the output pulse has
    // no combinational path from any input.
    always_ff @(posedge a_clk) begin
        if (a_reset) begin
            r_state      <= ST_IDLE;
            r_sync_pulse <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_state      <= w_state_next;
            r_sync_pulse <= (w_state_next == ST_ISSUE);
        end
    end

    // Pending-event counter; saturates at all-ones and never goes below 0
    // because ISSUE is only entered with a non-zero count.
    always_ff @(posedge a_clk) begin
        if (a_reset) begin
            r_pending <= '0;
        end else if (w_inc) begin
            r_pending <= r_pending + CW'(1);
        end else if (w_dec) begin
            r_pending <= r_pending - CW'(1);
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge a_clk) begin
        if (a_reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.a_clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.a_sync_pulse = r_sync_pulse;
    assign bus.a_pending    = r_pending;
    assign bus.a_full       = w_full;
    assign bus.a_overflow   = r_overflow;
    assign bus.a_idle       = (r_state == ST_IDLE) && (r_pending == '0);

endmodule

// File: tb/tb_cdc_pulse_feeder.sv
// Bench for cdc_pulse_feeder: one default-width instance and one CW=2
// instance, each with a small downstream busy model and a pulse scoreboard.
module tb_cdc_pulse_feeder;

    logic a_clk = 1'b0;
    logic a_reset;

    always #5 a_clk = ~a_clk;

    cdc_pulse_feeder_if #(.CW(8)) if8 ();
    cdc_pulse_feeder_if #(.CW(2)) if2 ();

    cdc_pulse_feeder #(.CW(8)) u_dut8 (
        .a_clk   (a_clk),
        .a_reset (a_reset),
        .bus     (if8.slave)
    );

    cdc_pulse_feeder #(.CW(2)) u_dut2 (
        .a_clk   (a_clk),
        .a_reset (a_reset),
        .bus     (if2.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Downstream busy model: after each pulse, busy for 'hold' cycles;
    // 'force' holds busy high regardless.
    int         hold8 = 0;
    int         hold2 = 0;
    logic       force2 = 1'b0;
    logic [3:0] cnt8 = '0;
    logic [3:0] cnt2 = '0;

    always @(posedge a_clk) begin
        if (a_reset) cnt8 <= '0;
        else if (if8.a_sync_pulse) cnt8 <= 4'(hold8);
        else if (cnt8 != 0) cnt8 <= cnt8 - 4'd1;
    end

    always @(posedge a_clk) begin
        if (a_reset) cnt2 <= '0;
        else if (if2.a_sync_pulse) cnt2 <= 4'(hold2);
        else if (cnt2 != 0) cnt2 <= cnt2 - 4'd1;
    end

    assign if8.a_sync_busy = (cnt8 != 0);
    assign if2.a_sync_busy = force2 | (cnt2 != 0);

    // Scoreboards: one token per accepted event, in issue order.
    int q8[$];
    int q2[$];
    int n_push8 = 0;
    int n_push2 = 0;
    int n_pulse8 = 0;
    int n_pulse2 = 0;

    always @(negedge a_clk) begin
        if (if8.a_sync_pulse === 1'b1) begin
            check("pulse8_busy_low", 32'(if8.a_sync_busy), 0);
            check("pulse8_expected", 32'(q8.size() != 0), 1);
            if (q8.size() != 0) check("pulse8_order", n_pulse8, q8.pop_front());
            n_pulse8 <= n_pulse8 + 1;
        end
    end

    always @(negedge a_clk) begin
        if (if2.a_sync_pulse === 1'b1) begin
            check("pulse2_busy_low", 32'(if2.a_sync_busy), 0);
            check("pulse2_expected", 32'(q2.size() != 0), 1);
            if (q2.size() != 0) check("pulse2_order", n_pulse2, q2.pop_front());
            n_pulse2 <= n_pulse2 + 1;
        end
    end

    task automatic tick();
        @(posedge a_clk);
        #1;
    endtask

    task automatic push8();
        q8.push_back(n_push8);
        n_push8++;
    endtask

    task automatic push2();
        q2.push_back(n_push2);
        n_push2++;
    endtask

    task automatic drain8(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (if8.a_idle && q8.size() == 0) break;
            tick();
        end
        check("drain8_queue", q8.size(), 0);
        check("drain8_idle", 32'(if8.a_idle), 1);
    endtask

    task automatic drain2(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (if2.a_idle && q2.size() == 0) break;
            tick();
        end
        check("drain2_queue", q2.size(), 0);
        check("drain2_idle", 32'(if2.a_idle), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        a_reset = 1'b1;
        if8.a_event_in = 1'b0;
        if8.a_clear_overflow = 1'b0;
        if2.a_event_in = 1'b0;
        if2.a_clear_overflow = 1'b0;

        // Reset, with event and clear also asserted to show reset wins.
        tick();
        if8.a_event_in = 1'b1;
        if8.a_clear_overflow = 1'b1;
        tick();
        check("rst_pending8", if8.a_pending, 0);
        check("rst_pulse8", 32'(if8.a_sync_pulse), 0);
        check("rst_full8", 32'(if8.a_full), 0);
        check("rst_idle8", 32'(if8.a_idle), 1);
        check("rst_ovf8", 32'(if8.a_overflow), 0);
        check("rst_pending2", if2.a_pending, 0);
        check("rst_full2", 32'(if2.a_full), 0);
        check("rst_idle2", 32'(if2.a_idle), 1);
        if8.a_event_in = 1'b0;
        if8.a_clear_overflow = 1'b0;
        a_reset = 1'b0;
        tick();
        check("post_rst_idle8", 32'(if8.a_idle), 1);

        // Single event, busy never asserted: pending 1 at N+1, pulse at N+2 only.
        hold8 = 0;
        if8.a_event_in = 1'b1;
        push8();
        tick();
        if8.a_event_in = 1'b0;
        check("single_pending_n1", if8.a_pending, 1);
        check("single_pulse_n1", 32'(if8.a_sync_pulse), 0);
        tick();
        check("single_pulse_n2", 32'(if8.a_sync_pulse), 1);
        tick();
        check("single_pulse_n3", 32'(if8.a_sync_pulse), 0);
        check("single_pending_n3", if8.a_pending, 0);
        tick();
        check("single_idle", 32'(if8.a_idle), 1);
        check("single_count", n_pulse8, 1);

        // Five back-to-back events, busy held 6 cycles per pulse.
        hold8 = 6;
        base = n_pulse8;
        for (int i = 0; i < 5; i++) begin
            if8.a_event_in = 1'b1;
            push8();
            tick();
        end
        if8.a_event_in = 1'b0;
        drain8(300);
        check("burst5_count", n_pulse8 - base, 5);
        check("burst5_pending", if8.a_pending, 0);
        check("burst5_ovf", 32'(if8.a_overflow), 0);

        // CW=2, busy forced: fill to saturation, fourth event is dropped.
        hold2 = 2;
        force2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if2.a_event_in = 1'b1;
            if (i < 3) push2();
            tick();
            if (i == 2) begin
                check("sat_pending3", if2.a_pending, 3);
                check("sat_full3", 32'(if2.a_full), 1);
                check("sat_ovf3", 32'(if2.a_overflow), 0);
            end
        end
        if2.a_event_in = 1'b0;
        check("sat_pending4", if2.a_pending, 3);
        check("sat_full4", 32'(if2.a_full), 1);
        check("sat_ovf4", 32'(if2.a_overflow), 1);
        base = n_pulse2;
        force2 = 1'b0;
        drain2(200);
        check("sat_release_count", n_pulse2 - base, 3);

        // Full counter with an event on the issue cycle: count stays 3.
        force2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if2.a_event_in = 1'b1;
            push2();
            tick();
        end
        if2.a_event_in = 1'b0;
        check("issue_full_pre", if2.a_pending, 3);
        base = n_pulse2;
        force2 = 1'b0;
        tick();
        check("issue_full_pulse", 32'(if2.a_sync_pulse), 1);
        if2.a_event_in = 1'b1;
        push2();
        tick();
        if2.a_event_in = 1'b0;
        check("issue_full_pending", if2.a_pending, 3);
        check("issue_full_ovf", 32'(if2.a_overflow), 1);
        drain2(200);
        check("issue_full_count", n_pulse2 - base, 4);

        // Clear alone, then clear together with a drop, then clear alone.
        if2.a_clear_overflow = 1'b1;
        tick();
        if2.a_clear_overflow = 1'b0;
        check("clear_alone1", 32'(if2.a_overflow), 0);
        force2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if2.a_event_in = 1'b1;
            push2();
            tick();
        end
        if2.a_clear_overflow = 1'b1;
        tick();
        if2.a_event_in = 1'b0;
        check("clear_vs_drop_ovf", 32'(if2.a_overflow), 1);
        check("clear_vs_drop_pend", if2.a_pending, 3);
        tick();
        if2.a_clear_overflow = 1'b0;
        check("clear_alone2", 32'(if2.a_overflow), 0);
        base = n_pulse2;
        force2 = 1'b0;
        drain2(200);
        check("clear_drain_count", n_pulse2 - base, 3);

        // Reset during WAIT with two events pending abandons them.
        hold8 = 6;
        base = n_pulse8;
        if8.a_event_in = 1'b1;
        push8();
        tick();
        check("rstwait_pending_c1", if8.a_pending, 1);
        tick();
        check("rstwait_pulse_c2", 32'(if8.a_sync_pulse), 1);
        tick();
        if8.a_event_in = 1'b0;
        check("rstwait_pending_c3", if8.a_pending, 2);
        check("rstwait_notidle_c3", 32'(if8.a_idle), 0);
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        check("rstwait_pending", if8.a_pending, 0);
        check("rstwait_idle", 32'(if8.a_idle), 1);
        check("rstwait_pulse", 32'(if8.a_sync_pulse), 0);
        for (int i = 0; i < 20; i++) tick();
        check("rstwait_no_more_pulses", n_pulse8 - base, 1);
        check("rstwait_idle_after", 32'(if8.a_idle), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
